sorted_lists_unpack: RTL and testbench

SORTED_LISTS_UNPACK -- requirements
Module: sorted_lists_unpack

---
 rtl/sorted_lists_unpack.sv | 133 +++++++++++++
 tb/tb_sorted_lists_unpack.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sorted_lists_unpack.sv
// sorted_lists_unpack: captures one sorted-list snapshot and drains its valid
// entries as a stream of beats in ascending index order, with a running sum of
// the entry sizes. Invalid entries are skipped without bubbles; an empty
// snapshot produces a single marker beat.
//
// in_tbl layout: entry i occupies in_tbl[i*97 +: 97] as {vld, key[63:0], size[31:0]},
// so vld is bit i*97+96, key is [i*97+32 +: 64], size is [i*97 +: 32].
module sorted_lists_unpack #(
    parameter int N = 4,
    parameter int M = 64,
    localparam int W_ID  = $clog2(M),
    localparam int W_IDX = (N > 1) ? $clog2(N) : 1,
    localparam int W_ENT = 97
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [W_ID-1:0]      in_id,
    input  logic [N*W_ENT-1:0]   in_tbl,
    output logic                 in_rdy,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [W_ID-1:0]      out_id,
    output logic [63:0]          out_key,
    output logic [31:0]          out_size,
    output logic [W_IDX-1:0]     out_idx,
    output logic [33:0]          out_sum,
    output logic                 out_last,
    output logic                 out_empty
);

    localparam logic IDLE  = 1'b0;
    localparam logic DRAIN = 1'b1;

    logic              state;
    logic [N-1:0]      pend;
    logic [63:0]       snap_key  [N];
    logic [31:0]       snap_size [N];
    logic [33:0]       acc;
    logic [W_ID-1:0]   id_q;
    logic              empty_q;

    logic [N-1:0]      tbl_vld;
    logic [63:0]       tbl_key  [N];
    logic [31:0]       tbl_size [N];

    logic [W_IDX-1:0]  cur_idx;
    logic [63:0]       cur_key;
    logic [31:0]       cur_size;
    logic              any_pend;
    logic              one_left;
    logic [N-1:0]      pend_m1;
    logic              accept;
    logic              hs;

    // Split the flat snapshot input into per-entry fields.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            tbl_vld[i]  = in_tbl[i*W_ENT + 96];
            tbl_key[i]  = in_tbl[i*W_ENT + 32 +: 64];
            tbl_size[i] = in_tbl[i*W_ENT +: 32];
        end
    end

    // Select the lowest-index pending entry; scanning downward lets the lowest win.
    always_comb begin
        cur_idx = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (pend[i-1]) begin
                cur_idx = W_IDX'(i - 1);
            end
        end
    end

    // Present the selected entry; an empty mask presents all-zero data.
    always_comb begin
        any_pend = |pend;
        pend_m1  = pend - N'(1);
        one_left = any_pend && ((pend & pend_m1) == '0);
        cur_key  = any_pend ? snap_key[cur_idx]  : '0;
        cur_size = any_pend ? snap_size[cur_idx] : '0;
    end

    // Output and handshake decode. in_rdy is forced low while reset is held.
    always_comb begin
        out_vld   = (state == DRAIN);
        out_id    = id_q;
        out_empty = empty_q;
        out_key   = cur_key;
        out_size  = cur_size;
        out_idx   = cur_idx;
        out_sum   = acc + {2'b00, cur_size};
        out_last  = out_vld & (empty_q | one_left);
        hs        = out_vld & out_rdy;
        in_rdy    = ~rst & ((state == IDLE) | (hs & out_last));
        accept    = in_vld & in_rdy;
    end

    // Snapshot capture, drain progress and running-sum accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pend    <= '0;
            acc     <= '0;
            id_q    <= '0;
            empty_q <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                snap_key[i]  <= '0;
                snap_size[i] <= '0;
            end
        end else if (accept) begin
            state   <= DRAIN;
            pend    <= tbl_vld;
            acc     <= '0;
            id_q    <= in_id;
            empty_q <= ~|tbl_vld;
            for (int unsigned i = 0; i < N; i++) begin
                snap_key[i]  <= tbl_key[i];
                snap_size[i] <= tbl_size[i];
            end
        end else if (hs) begin
            if (out_last) begin
                state <= IDLE;
                pend  <= '0;
                acc   <= '0;
            end else begin
                pend <= pend & ~(N'(1) << cur_idx);
                acc  <= out_sum;
            end
        end
    end

endmodule

// File: tb/tb_sorted_lists_unpack.sv
// Directed bench for sorted_lists_unpack: full, sparse, empty, backpressure,
// back-to-back with maximum sizes, and reset during drain.
module tb_sorted_lists_unpack;

    localparam int N = 4;
    localparam int M = 64;
    localparam int W_ENT = 97;

    logic              clk;
    logic              rst;
    logic              in_vld;
    logic [5:0]        in_id;
    logic [N*W_ENT-1:0] in_tbl;
    logic              in_rdy;
    logic              out_vld;
    logic              out_rdy;
    logic [5:0]        out_id;
    logic [63:0]       out_key;
    logic [31:0]       out_size;
    logic [1:0]        out_idx;
    logic [33:0]       out_sum;
    logic              out_last;
    logic              out_empty;

    int unsigned n_checks;
    int unsigned n_fail;

    sorted_lists_unpack #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vld    (in_vld),
        .in_id     (in_id),
        .in_tbl    (in_tbl),
        .in_rdy    (in_rdy),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_id    (out_id),
        .out_key   (out_key),
        .out_size  (out_size),
        .out_idx   (out_idx),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_empty (out_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tbl(input logic [3:0] v,
                           input logic [63:0] k0, input logic [63:0] k1,
                           input logic [63:0] k2, input logic [63:0] k3,
                           input logic [31:0] s0, input logic [31:0] s1,
                           input logic [31:0] s2, input logic [31:0] s3);
        in_tbl = {{v[3], k3, s3}, {v[2], k2, s2}, {v[1], k1, s1}, {v[0], k0, s0}};
    endtask

    task automatic beat(input string tag, input logic [5:0] id, input logic [1:0] idx,
                        input logic [63:0] key, input logic [31:0] size,
                        input logic [33:0] sum, input logic last, input logic empty,
                        input logic rdy);
        #1;
        chk({tag, ".vld"},   64'(out_vld),   64'd1);
        chk({tag, ".id"},    64'(out_id),    64'(id));
        chk({tag, ".idx"},   64'(out_idx),   64'(idx));
        chk({tag, ".key"},   out_key,        key);
        chk({tag, ".size"},  64'(out_size),  64'(size));
        chk({tag, ".sum"},   64'(out_sum),   64'(sum));
        chk({tag, ".last"},  64'(out_last),  64'(last));
        chk({tag, ".empty"}, 64'(out_empty), 64'(empty));
        chk({tag, ".in_rdy"},64'(in_rdy),    64'(rdy));
    endtask

    task automatic idle_chk(input string tag);
        #1;
        chk({tag, ".vld"},    64'(out_vld), 64'd0);
        chk({tag, ".in_rdy"}, 64'(in_rdy),  64'd1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        in_vld   = 1'b0;
        in_id    = '0;
        in_tbl   = '0;
        out_rdy  = 1'b0;

        // Reset state
        step();
        step();
        chk("rst.in_rdy", 64'(in_rdy),    64'd0);
        chk("rst.vld",    64'(out_vld),   64'd0);
        chk("rst.sum",    64'(out_sum),   64'd0);
        chk("rst.last",   64'(out_last),  64'd0);
        chk("rst.empty",  64'(out_empty), 64'd0);
        chk("rst.key",    out_key,        64'd0);
        chk("rst.id",     64'(out_id),    64'd0);
        rst = 1'b0;
        #1;
        chk("rel.in_rdy", 64'(in_rdy), 64'd1);

        // Full list
        in_vld = 1'b1; in_id = 6'd5; out_rdy = 1'b1;
        set_tbl(4'b1111, 64'd10, 64'd20, 64'd30, 64'd40, 32'd1, 32'd2, 32'd3, 32'd4);
        step();
        in_vld = 1'b0;
        beat("full0", 6'd5, 2'd0, 64'd10, 32'd1, 34'd1, 1'b0, 1'b0, 1'b0);
        step(); beat("full1", 6'd5, 2'd1, 64'd20, 32'd2, 34'd3,  1'b0, 1'b0, 1'b0);
        step(); beat("full2", 6'd5, 2'd2, 64'd30, 32'd3, 34'd6,  1'b0, 1'b0, 1'b0);
        step(); beat("full3", 6'd5, 2'd3, 64'd40, 32'd4, 34'd10, 1'b1, 1'b0, 1'b1);
        step(); idle_chk("full.end");

        // Sparse list
        in_vld = 1'b1; in_id = 6'd2;
        set_tbl(4'b1010, 64'd99, 64'd7, 64'd98, 64'd9, 32'd50, 32'd100, 32'd60, 32'd5);
        step();
        in_vld = 1'b0;
        beat("sparse0", 6'd2, 2'd1, 64'd7, 32'd100, 34'd100, 1'b0, 1'b0, 1'b0);
        step(); beat("sparse1", 6'd2, 2'd3, 64'd9, 32'd5, 34'd105, 1'b1, 1'b0, 1'b1);
        step(); idle_chk("sparse.end");

        // Empty list
        in_vld = 1'b1; in_id = 6'd63;
        set_tbl(4'b0000, 64'd1, 64'd2, 64'd3, 64'd4, 32'd1, 32'd2, 32'd3, 32'd4);
        step();
        in_vld = 1'b0;
        beat("empty0", 6'd63, 2'd0, 64'd0, 32'd0, 34'd0, 1'b1, 1'b1, 1'b1);
        step(); idle_chk("empty.end");

        // Backpressure on beat 2
        in_vld = 1'b1; in_id = 6'd1;
        set_tbl(4'b1111, 64'd10, 64'd20, 64'd30, 64'd40, 32'd1, 32'd2, 32'd3, 32'd4);
        step();
        in_vld = 1'b0;
        beat("bp0", 6'd1, 2'd0, 64'd10, 32'd1, 34'd1, 1'b0, 1'b0, 1'b0);
        step();
        out_rdy = 1'b0;
        beat("bp1a", 6'd1, 2'd1, 64'd20, 32'd2, 34'd3, 1'b0, 1'b0, 1'b0);
        step(); beat("bp1b", 6'd1, 2'd1, 64'd20, 32'd2, 34'd3, 1'b0, 1'b0, 1'b0);
        step(); beat("bp1c", 6'd1, 2'd1, 64'd20, 32'd2, 34'd3, 1'b0, 1'b0, 1'b0);
        out_rdy = 1'b1;
        step(); beat("bp2", 6'd1, 2'd2, 64'd30, 32'd3, 34'd6,  1'b0, 1'b0, 1'b0);
        step(); beat("bp3", 6'd1, 2'd3, 64'd40, 32'd4, 34'd10, 1'b1, 1'b0, 1'b1);
        step(); idle_chk("bp.end");

        // Back-to-back, second snapshot with maximum sizes
        in_vld = 1'b1; in_id = 6'd3;
        set_tbl(4'b1111, 64'd10, 64'd20, 64'd30, 64'd40, 32'd1, 32'd2, 32'd3, 32'd4);
        step();
        in_id = 6'd4;
        set_tbl(4'b1111, 64'd100, 64'd101, 64'd102, 64'd103,
                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        beat("b2bA0", 6'd3, 2'd0, 64'd10, 32'd1, 34'd1, 1'b0, 1'b0, 1'b0);
        step(); beat("b2bA1", 6'd3, 2'd1, 64'd20, 32'd2, 34'd3,  1'b0, 1'b0, 1'b0);
        step(); beat("b2bA2", 6'd3, 2'd2, 64'd30, 32'd3, 34'd6,  1'b0, 1'b0, 1'b0);
        step(); beat("b2bA3", 6'd3, 2'd3, 64'd40, 32'd4, 34'd10, 1'b1, 1'b0, 1'b1);
        step();
        in_vld = 1'b0;
        beat("b2bB0", 6'd4, 2'd0, 64'd100, 32'hFFFF_FFFF, 34'h0_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        step(); beat("b2bB1", 6'd4, 2'd1, 64'd101, 32'hFFFF_FFFF, 34'h1_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        step(); beat("b2bB2", 6'd4, 2'd2, 64'd102, 32'hFFFF_FFFF, 34'h2_FFFF_FFFD, 1'b0, 1'b0, 1'b0);
        step(); beat("b2bB3", 6'd4, 2'd3, 64'd103, 32'hFFFF_FFFF, 34'h3_FFFF_FFFC, 1'b1, 1'b0, 1'b1);
        step(); idle_chk("b2b.end");

        // Reset during drain after beat 1
        in_vld = 1'b1; in_id = 6'd7;
        set_tbl(4'b1111, 64'd10, 64'd20, 64'd30, 64'd40, 32'd1, 32'd2, 32'd3, 32'd4);
        step();
        in_vld = 1'b0;
        beat("mr0", 6'd7, 2'd0, 64'd10, 32'd1, 34'd1, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        chk("mr.vld",    64'(out_vld),  64'd0);
        chk("mr.in_rdy", 64'(in_rdy),   64'd0);
        chk("mr.id",     64'(out_id),   64'd0);
        chk("mr.sum",    64'(out_sum),  64'd0);
        chk("mr.key",    out_key,       64'd0);
        chk("mr.size",   64'(out_size), 64'd0);
        chk("mr.idx",    64'(out_idx),  64'd0);
        chk("mr.last",   64'(out_last), 64'd0);
        rst = 1'b0;
        #1;
        chk("mr.rel.in_rdy", 64'(in_rdy), 64'd1);
        in_vld = 1'b1; in_id = 6'd9;
        set_tbl(4'b1111, 64'd11, 64'd12, 64'd13, 64'd14, 32'd5, 32'd6, 32'd7, 32'd8);
        step();
        in_vld = 1'b0;
        beat("post0", 6'd9, 2'd0, 64'd11, 32'd5, 34'd5,  1'b0, 1'b0, 1'b0);
        step(); beat("post1", 6'd9, 2'd1, 64'd12, 32'd6, 34'd11, 1'b0, 1'b0, 1'b0);
        step(); beat("post2", 6'd9, 2'd2, 64'd13, 32'd7, 34'd18, 1'b0, 1'b0, 1'b0);
        step(); beat("post3", 6'd9, 2'd3, 64'd14, 32'd8, 34'd26, 1'b1, 1'b0, 1'b1);
        step(); idle_chk("post.end");

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
